// File: rtl/serial_subtractor_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl_pkg
//   Shared definitions for the bit-serial subtractor controller.
//   - state_t     : FSM state encoding (IDLE/RUN/DONE; the unused code 2'd3
//                   is treated as illegal and steered back to IDLE)
//   - MAX_WIDTH   : largest supported operand width
//   - countWidth  : width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_subtractor_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

  // Enough bits to hold 0..width, so the counter can never wrap while running.
  function automatic int countWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// ---------------------------------------------------------------------------
// serial_sub_cell
//   Combinational 1-bit full subtractor: computes a - b - bin.
//   Ports:
//     i_a     in   1   minuend bit
//     i_b     in   1   subtrahend bit
//     i_bin   in   1   borrow in from the less significant bit
//     o_d     out  1   difference bit
//     o_bout  out  1   borrow out toward the more significant bit
// ---------------------------------------------------------------------------
module serial_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_axb;

  // A borrow is generated when a=0,b=1 and propagated when a==b.
  always_comb begin
    w_axb  = i_a ^ i_b;
    o_d    = w_axb ^ i_bin;
    o_bout = (~i_a & i_b) | (~w_axb & i_bin);
  end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
//   Bit-serial WIDTH-bit subtractor. One full-subtract cell is stepped
//   LSB-first over WIDTH clock cycles to form a_in - b_in, with a
//   start/done handshake toward the host.
//   Parameters:
//     WIDTH        operand/result width, 1..32
//   Ports:
//     clk          in   1      rising-edge clock
//     rst          in   1      synchronous active-high reset
//     start        in   1      request, accepted only while ready=1
//     a_in         in   WIDTH  minuend, sampled on the accepting edge
//     b_in         in   WIDTH  subtrahend, sampled on the accepting edge
//     ready        out  1      high in IDLE
//     busy         out  1      high in RUN and DONE
//     done         out  1      one-cycle pulse, result valid
//     diff_out     out  WIDTH  (a_in - b_in) mod 2^WIDTH, held until the next result
//     borrow_out   out  1      final borrow (a_in < b_in unsigned), held like diff_out
// ---------------------------------------------------------------------------
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int CW = countWidth(WIDTH);

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bor;
  logic             r_borrowOut;
  logic [CW-1:0]    r_count;

  logic             w_d;
  logic             w_bout;
  logic             w_lastBit;
  logic [WIDTH-1:0] w_resNext;

  serial_sub_cell u_cell (
    .i_a    (r_aSh[0]),
    .i_b    (r_bSh[0]),
    .i_bin  (r_bor),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // The new difference bit enters at the MSB end while older bits move
  // toward the LSB; written as shifts so it also holds for WIDTH=1.
  always_comb begin
    w_lastBit = (r_count == CW'(WIDTH - 1));
    w_resNext = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and status decode; handshake outputs come purely from state.
  always_comb begin
    w_stateNext = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_lastBit) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Datapath: operand load on acceptance, one bit per RUN cycle, and the
  // result registers updated only on the final RUN edge so they stay stable
  // across idle time and ignored starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aSh       <= '0;
      r_bSh       <= '0;
      r_res       <= '0;
      r_diff      <= '0;
      r_bor       <= 1'b0;
      r_borrowOut <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_aSh   <= a_in;
            r_bSh   <= b_in;
            r_bor   <= 1'b0;
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_aSh   <= r_aSh >> 1;
          r_bSh   <= r_bSh >> 1;
          r_res   <= w_resNext;
          r_bor   <= w_bout;
          r_count <= r_count + CW'(1);
          if (w_lastBit) begin
            r_diff      <= w_resNext;
            r_borrowOut <= w_bout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff_out   = r_diff;
  assign borrow_out = r_borrowOut;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_ctrl
//   Self-checking bench for serial_subtractor_ctrl at WIDTH = 8, 4 and 1.
//   Expected results come from plain modular arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       startV [3];
  logic [7:0] aV     [3];
  logic [7:0] bV     [3];
  logic       readyV [3];
  logic       busyV  [3];
  logic       doneV  [3];
  logic       borV   [3];
  logic [7:0] diff8;
  logic [3:0] diff4;
  logic [0:0] diff1;

  int         widths [3] = '{8, 4, 1};
  logic [7:0] prevDiff [3];
  logic       prevBor  [3];

  int sel = 0;
  logic       readyS, busyS, doneS, borS;
  logic [7:0] diffS;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(startV[0]), .a_in(aV[0]), .b_in(bV[0]),
    .ready(readyV[0]), .busy(busyV[0]), .done(doneV[0]),
    .diff_out(diff8), .borrow_out(borV[0])
  );

  serial_subtractor_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(startV[1]), .a_in(aV[1][3:0]), .b_in(bV[1][3:0]),
    .ready(readyV[1]), .busy(busyV[1]), .done(doneV[1]),
    .diff_out(diff4), .borrow_out(borV[1])
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(startV[2]), .a_in(aV[2][0:0]), .b_in(bV[2][0:0]),
    .ready(readyV[2]), .busy(busyV[2]), .done(doneV[2]),
    .diff_out(diff1), .borrow_out(borV[2])
  );

  // Present the outputs of whichever instance is currently under test.
  always_comb begin
    readyS = readyV[sel];
    busyS  = busyV[sel];
    doneS  = doneV[sel];
    borS   = borV[sel];
    case (sel)
      1:       diffS = {4'b0, diff4};
      2:       diffS = {7'b0, diff1};
      default: diffS = diff8;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation on instance idx. Called #1 after a rising edge; returns the
  // same way. injectAt>0 pulses start with fresh operands in that RUN cycle;
  // resetAt>0 asserts rst in that RUN cycle and abandons the operation.
  task automatic applyStimulus(input int idx, input logic [7:0] aIn, input logic [7:0] bIn,
                               input int injectAt, input int resetAt);
    int         w;
    int         mask;
    int         latency;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expD;
    logic       expB;
    w       = widths[idx];
    mask    = (1 << w) - 1;
    a       = 8'(int'(aIn) & mask);
    b       = 8'(int'(bIn) & mask);
    expD    = 8'((int'(a) - int'(b)) & mask);
    expB    = (a < b);
    latency = 0;
    sel     = idx;
    #0;
    checkOutput("ready_before_start", 32'(readyS), 32'd1);
    startV[idx] = 1'b1;
    aV[idx]     = a;
    bV[idx]     = b;
    @(posedge clk);
    #1;
    startV[idx] = 1'b0;
    aV[idx]     = 8'($urandom);
    bV[idx]     = 8'($urandom);
    checkOutput("busy_after_accept", 32'(busyS), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      startV[idx] = 1'b0;
      if (doneS) begin
        latency = k;
        break;
      end
      checkOutput("diff_held_during_run", 32'(diffS), 32'(prevDiff[idx]));
      if (k == injectAt) begin
        startV[idx] = 1'b1;
        aV[idx]     = 8'($urandom);
        bV[idx]     = 8'($urandom);
      end
      if (k == resetAt) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_mid_run_ready", 32'(readyS), 32'd1);
        checkOutput("reset_mid_run_busy", 32'(busyS), 32'd0);
        checkOutput("reset_mid_run_done", 32'(doneS), 32'd0);
        checkOutput("reset_mid_run_diff", 32'(diffS), 32'd0);
        checkOutput("reset_mid_run_borrow", 32'(borS), 32'd0);
        for (int j = 0; j < 3; j++) begin
          prevDiff[j] = 8'd0;
          prevBor[j]  = 1'b0;
        end
        for (int j = 0; j < w + 3; j++) begin
          @(posedge clk);
          #1;
          checkOutput("no_done_after_abort", 32'(doneS), 32'd0);
        end
        return;
      end
    end
    checkOutput("done_latency", 32'(latency), 32'(w));
    checkOutput("diff_out", 32'(diffS), 32'(expD));
    checkOutput("borrow_out", 32'(borS), 32'(expB));
    checkOutput("busy_in_done", 32'(busyS), 32'd1);
    checkOutput("ready_in_done", 32'(readyS), 32'd0);
    prevDiff[idx] = expD;
    prevBor[idx]  = expB;
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", 32'(doneS), 32'd0);
    checkOutput("ready_after_done", 32'(readyS), 32'd1);
    checkOutput("busy_after_done", 32'(busyS), 32'd0);
    checkOutput("diff_held_idle", 32'(diffS), 32'(expD));
    checkOutput("borrow_held_idle", 32'(borS), 32'(expB));
    if (injectAt > 0) begin
      for (int j = 0; j < w + 2; j++) begin
        @(posedge clk);
        #1;
        checkOutput("no_extra_done", 32'(doneS), 32'd0);
        checkOutput("diff_unchanged_after_ignored_start", 32'(diffS), 32'(expD));
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      startV[j]   = 1'b0;
      aV[j]       = 8'd0;
      bV[j]       = 8'd0;
      prevDiff[j] = 8'd0;
      prevBor[j]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      sel = j;
      #0;
      checkOutput("reset_ready", 32'(readyS), 32'd1);
      checkOutput("reset_busy", 32'(busyS), 32'd0);
      checkOutput("reset_done", 32'(doneS), 32'd0);
      checkOutput("reset_diff", 32'(diffS), 32'd0);
      checkOutput("reset_borrow", 32'(borS), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed WIDTH=8 operations");
    applyStimulus(0, 8'd20, 8'd7, 0, 0);
    applyStimulus(0, 8'd7, 8'd20, 0, 0);
    applyStimulus(0, 8'd0, 8'd0, 0, 0);
    applyStimulus(0, 8'd255, 8'd255, 0, 0);
    applyStimulus(0, 8'd0, 8'd1, 0, 0);
    applyStimulus(0, 8'd255, 8'd0, 0, 0);

    $display("[TB] start pulsed mid-run");
    applyStimulus(0, 8'd100, 8'd58, 3, 0);

    $display("[TB] reset in the middle of a run");
    applyStimulus(0, 8'd77, 8'd33, 0, 4);
    applyStimulus(0, 8'd33, 8'd77, 0, 0);

    $display("[TB] random WIDTH=8 operations");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 8'($urandom), 8'($urandom), 0, 0);
    end

    $display("[TB] exhaustive WIDTH=1 and WIDTH=4, back to back");
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        applyStimulus(2, 8'(a), 8'(b), 0, 0);
      end
    end
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(1, 8'(a), 8'(b), 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
